// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, one op in flight.
// Optional macro DIV_EARLY_OUT_EN: finish at accept when |rs1| < |rs2|.
module exu_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            div_valid,
    input  logic            div_rem,
    input  logic            div_unsign,
    input  logic [XLEN-1:0] div_rs1_data,
    input  logic [XLEN-1:0] div_rs2_data,
    input  logic [4:0]      div_rd_addr,
    input  logic [XLEN-1:0] div_instr_tag,
    output logic            div_busy,
    output logic            div_wb_valid,
    output logic            div_wb_rd_wr_en,
    output logic [4:0]      div_wb_rd_addr,
    output logic [XLEN-1:0] div_wb_data,
    output logic [XLEN-1:0] div_wb_instr_tag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        if (sgn && v[XLEN-1]) begin
            abs_val = -v;
        end else begin
            abs_val = v;
        end
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              rem_r;
    logic              q_neg_r;
    logic              r_neg_r;
    logic [4:0]        rd_addr_r;
    logic [XLEN-1:0]   tag_r;
    logic [XLEN-1:0]   dvd_r;
    logic [XLEN-1:0]   dvs_r;
    logic [XLEN:0]     prem_r;

    logic              busy_r;
    logic              wb_valid_r;
    logic              wb_rd_wr_en_r;
    logic [4:0]        wb_rd_addr_r;
    logic [XLEN-1:0]   wb_data_r;
    logic [XLEN-1:0]   wb_tag_r;

    logic [XLEN-1:0]   rs1_abs_s;
    logic [XLEN-1:0]   rs2_abs_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic              early_s;
    logic              special_s;
    logic              q_sign_s;
    logic              r_sign_s;
    logic [XLEN-1:0]   spec_q_s;
    logic [XLEN-1:0]   spec_r_s;
    logic [XLEN-1:0]   spec_data_s;

    logic [XLEN:0]     shift_s;
    logic [XLEN+1:0]   diff_s;
    logic              qbit_s;
    logic [XLEN:0]     prem_nxt_s;
    logic [XLEN-1:0]   quo_nxt_s;
    logic [XLEN-1:0]   rem_mag_s;
    logic [XLEN-1:0]   quo_fin_s;
    logic [XLEN-1:0]   rem_fin_s;
    logic [XLEN-1:0]   calc_data_s;

    // Accept-time decode: operand magnitudes, result signs and the no-iteration cases
    always_comb begin
        rs1_abs_s  = abs_val(div_rs1_data, ~div_unsign);
        rs2_abs_s  = abs_val(div_rs2_data, ~div_unsign);
        div_zero_s = (div_rs2_data == '0);
        ovf_s      = ~div_unsign && (div_rs1_data == MIN_VAL) && (div_rs2_data == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
        early_s    = (rs1_abs_s < rs2_abs_s);
`else
        early_s    = 1'b0;
`endif
        special_s  = div_zero_s | ovf_s | early_s;
        q_sign_s   = ~div_unsign & (div_rs1_data[XLEN-1] ^ div_rs2_data[XLEN-1]);
        r_sign_s   = ~div_unsign & div_rs1_data[XLEN-1];
        // divide-by-zero wins; early-out can never fire with a zero divisor anyway
        if (div_zero_s) begin
            spec_q_s = ALL_ONES;
            spec_r_s = div_rs1_data;
        end else if (ovf_s) begin
            spec_q_s = div_rs1_data;
            spec_r_s = '0;
        end else begin
            spec_q_s = '0;
            spec_r_s = div_rs1_data;
        end
        if (div_rem) begin
            spec_data_s = spec_r_s;
        end else begin
            spec_data_s = spec_q_s;
        end
    end

    // One restoring step plus the sign-corrected result used on the final step
    always_comb begin
        shift_s = {prem_r[XLEN-1:0], dvd_r[XLEN-1]};
        diff_s  = {1'b0, shift_s} - {2'b00, dvs_r};
        if (diff_s[XLEN+1]) begin
            prem_nxt_s = shift_s;
            qbit_s     = 1'b0;
        end else begin
            prem_nxt_s = diff_s[XLEN:0];
            qbit_s     = 1'b1;
        end
        quo_nxt_s = {dvd_r[XLEN-2:0], qbit_s};
        rem_mag_s = prem_nxt_s[XLEN-1:0];
        if (q_neg_r) begin
            quo_fin_s = -quo_nxt_s;
        end else begin
            quo_fin_s = quo_nxt_s;
        end
        if (r_neg_r) begin
            rem_fin_s = -rem_mag_s;
        end else begin
            rem_fin_s = rem_mag_s;
        end
        if (rem_r) begin
            calc_data_s = rem_fin_s;
        end else begin
            calc_data_s = quo_fin_s;
        end
    end

    // Control FSM, datapath registers and registered write-back outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            rem_r         <= 1'b0;
            q_neg_r       <= 1'b0;
            r_neg_r       <= 1'b0;
            rd_addr_r     <= 5'd0;
            tag_r         <= '0;
            dvd_r         <= '0;
            dvs_r         <= '0;
            prem_r        <= '0;
            busy_r        <= 1'b0;
            wb_valid_r    <= 1'b0;
            wb_rd_wr_en_r <= 1'b0;
            wb_rd_addr_r  <= 5'd0;
            wb_data_r     <= '0;
            wb_tag_r      <= '0;
        end else begin
            wb_valid_r    <= 1'b0;
            wb_rd_wr_en_r <= 1'b0;
            if (pipe_flush) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (div_valid) begin
                            rem_r     <= div_rem;
                            rd_addr_r <= div_rd_addr;
                            tag_r     <= div_instr_tag;
                            busy_r    <= 1'b1;
                            if (special_s) begin
                                state_r       <= DONE;
                                wb_valid_r    <= 1'b1;
                                wb_rd_wr_en_r <= (div_rd_addr != 5'd0);
                                wb_rd_addr_r  <= div_rd_addr;
                                wb_data_r     <= spec_data_s;
                                wb_tag_r      <= div_instr_tag;
                            end else begin
                                state_r <= CALC;
                                dvd_r   <= rs1_abs_s;
                                dvs_r   <= rs2_abs_s;
                                prem_r  <= '0;
                                cnt_r   <= CNT_W'(XLEN);
                                q_neg_r <= q_sign_s;
                                r_neg_r <= r_sign_s;
                            end
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    CALC: begin
                        dvd_r  <= quo_nxt_s;
                        prem_r <= prem_nxt_s;
                        cnt_r  <= cnt_r - CNT_W'(1);
                        // last step: publish the sign-corrected result directly
                        if (cnt_r == CNT_W'(1)) begin
                            state_r       <= DONE;
                            wb_valid_r    <= 1'b1;
                            wb_rd_wr_en_r <= (rd_addr_r != 5'd0);
                            wb_rd_addr_r  <= rd_addr_r;
                            wb_data_r     <= calc_data_s;
                            wb_tag_r      <= tag_r;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign div_busy         = busy_r;
    assign div_wb_valid     = wb_valid_r;
    assign div_wb_rd_wr_en  = wb_rd_wr_en_r;
    assign div_wb_rd_addr   = wb_rd_addr_r;
    assign div_wb_data      = wb_data_r;
    assign div_wb_instr_tag = wb_tag_r;

endmodule

// File: tb/tb_exu_div.sv
// Directed bench for exu_div (XLEN=32): latency, signed/unsigned results, special
// cases, busy hold-off, flush and mid-operation reset.
module tb_exu_div;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            pipe_flush;
    logic            div_valid;
    logic            div_rem;
    logic            div_unsign;
    logic [XLEN-1:0] div_rs1_data;
    logic [XLEN-1:0] div_rs2_data;
    logic [4:0]      div_rd_addr;
    logic [XLEN-1:0] div_instr_tag;
    logic            div_busy;
    logic            div_wb_valid;
    logic            div_wb_rd_wr_en;
    logic [4:0]      div_wb_rd_addr;
    logic [XLEN-1:0] div_wb_data;
    logic [XLEN-1:0] div_wb_instr_tag;

    int n_chk;
    int n_pass;

    exu_div #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pipe_flush       (pipe_flush),
        .div_valid        (div_valid),
        .div_rem          (div_rem),
        .div_unsign       (div_unsign),
        .div_rs1_data     (div_rs1_data),
        .div_rs2_data     (div_rs2_data),
        .div_rd_addr      (div_rd_addr),
        .div_instr_tag    (div_instr_tag),
        .div_busy         (div_busy),
        .div_wb_valid     (div_wb_valid),
        .div_wb_rd_wr_en  (div_wb_rd_wr_en),
        .div_wb_rd_addr   (div_wb_rd_addr),
        .div_wb_data      (div_wb_data),
        .div_wb_instr_tag (div_wb_instr_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, then measure edges from the accept edge to the write-back pulse
    task automatic run_op(input string name, input logic rem, input logic uns,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] tag, input logic [31:0] exp_data, input int exp_lat);
        int lat;
        @(negedge clk);
        div_valid     = 1'b1;
        div_rem       = rem;
        div_unsign    = uns;
        div_rs1_data  = a;
        div_rs2_data  = b;
        div_rd_addr   = rd;
        div_instr_tag = tag;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        check({name, "/busy"}, 64'(div_busy), 64'd1);
        lat = 0;
        while (!div_wb_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "/lat"}, 64'(lat), 64'(exp_lat));
        check({name, "/data"}, 64'(div_wb_data), 64'(exp_data));
        check({name, "/tag"}, 64'(div_wb_instr_tag), 64'(tag));
        check({name, "/rd"}, 64'(div_wb_rd_addr), 64'(rd));
        check({name, "/wren"}, 64'(div_wb_rd_wr_en), 64'((rd != 5'd0) ? 1 : 0));
        @(posedge clk);
        #1;
        check({name, "/pulse"}, 64'(div_wb_valid), 64'd0);
        check({name, "/idle"}, 64'(div_busy), 64'd0);
    endtask

    initial begin
        int wb_cnt;
        int wb_cyc [2];
        logic [31:0] wb_dat [2];
        logic [31:0] wb_tg  [2];
        logic was_idle;

        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        pipe_flush = 1'b0;
        div_valid = 1'b0;
        div_rem = 1'b0;
        div_unsign = 1'b0;
        div_rs1_data = 32'd0;
        div_rs2_data = 32'd0;
        div_rd_addr = 5'd0;
        div_instr_tag = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/busy", 64'(div_busy), 64'd0);
        check("rst/valid", 64'(div_wb_valid), 64'd0);
        check("rst/wren", 64'(div_wb_rd_wr_en), 64'd0);
        check("rst/rd", 64'(div_wb_rd_addr), 64'd0);
        check("rst/data", 64'(div_wb_data), 64'd0);
        check("rst/tag", 64'(div_wb_instr_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu100_7", 1'b0, 1'b1, 32'd100, 32'd7, 5'd5, 32'h11, 32'd14, XLEN);
        run_op("remu100_7", 1'b1, 1'b1, 32'd100, 32'd7, 5'd5, 32'h12, 32'd2, XLEN);
        run_op("div_m7_2", 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h13, 32'hFFFF_FFFD, XLEN);
        run_op("rem_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h14, 32'hFFFF_FFFF, XLEN);
        run_op("rem_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'h15, 32'd1, XLEN);
        run_op("div_6_m3", 1'b0, 1'b0, 32'd6, 32'hFFFF_FFFD, 5'd7, 32'h16, 32'hFFFF_FFFE, XLEN);
        run_op("divu_big", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, 5'd8, 32'h17, 32'h0FFF_FFFF, XLEN);
        run_op("remu_big", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h10, 5'd0, 32'h18, 32'hF, XLEN);
        run_op("div5_0", 1'b0, 1'b0, 32'd5, 32'd0, 5'd9, 32'h19, 32'hFFFF_FFFF, 0);
        run_op("remu5_0", 1'b1, 1'b1, 32'd5, 32'd0, 5'd9, 32'h1A, 32'd5, 0);
        run_op("div_ovf", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h1B, 32'h8000_0000, 0);
        run_op("rem_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h1C, 32'd0, 0);
`ifdef DIV_EARLY_OUT_EN
        run_op("divu3_10", 1'b0, 1'b1, 32'd3, 32'd10, 5'd11, 32'h1D, 32'd0, 0);
`else
        run_op("divu3_10", 1'b0, 1'b1, 32'd3, 32'd10, 5'd11, 32'h1D, 32'd0, XLEN);
`endif

        // second request held high while busy: accepted only once the unit is idle
        @(negedge clk);
        div_valid = 1'b1;
        div_rem = 1'b0;
        div_unsign = 1'b1;
        div_rs1_data = 32'd100;
        div_rs2_data = 32'd7;
        div_rd_addr = 5'd3;
        div_instr_tag = 32'hA1;
        @(posedge clk);
        #1;
        div_rs1_data = 32'd50;
        div_rs2_data = 32'd5;
        div_rd_addr = 5'd4;
        div_instr_tag = 32'hB2;
        wb_cnt = 0;
        was_idle = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk);
            #1;
            if (was_idle && div_valid) div_valid = 1'b0;
            was_idle = !div_busy;
            if (div_wb_valid) begin
                if (wb_cnt < 2) begin
                    wb_cyc[wb_cnt] = c;
                    wb_dat[wb_cnt] = div_wb_data;
                    wb_tg[wb_cnt] = div_wb_instr_tag;
                end
                wb_cnt++;
            end
        end
        div_valid = 1'b0;
        check("hold/count", 64'(wb_cnt), 64'd2);
        check("hold/data0", 64'(wb_dat[0]), 64'd14);
        check("hold/tag0", 64'(wb_tg[0]), 64'hA1);
        check("hold/data1", 64'(wb_dat[1]), 64'd10);
        check("hold/tag1", 64'(wb_tg[1]), 64'hB2);
        check("hold/gap", 64'(wb_cyc[1] - wb_cyc[0]), 64'(XLEN + 2));

        // flush ten cycles into a DIVU: no write-back, unit reusable
        @(negedge clk);
        div_valid = 1'b1;
        div_rem = 1'b0;
        div_unsign = 1'b1;
        div_rs1_data = 32'd1000;
        div_rs2_data = 32'd3;
        div_rd_addr = 5'd12;
        div_instr_tag = 32'hC3;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        pipe_flush = 1'b1;
        @(posedge clk);
        #1;
        pipe_flush = 1'b0;
        check("flush/busy", 64'(div_busy), 64'd0);
        wb_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (div_wb_valid) wb_cnt++;
        end
        check("flush/nowb", 64'(wb_cnt), 64'd0);
        run_op("divu9_3", 1'b0, 1'b1, 32'd9, 32'd3, 5'd13, 32'hD4, 32'd3, XLEN);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        div_valid = 1'b1;
        div_rs1_data = 32'd1000;
        div_rs2_data = 32'd7;
        div_rd_addr = 5'd9;
        div_instr_tag = 32'h55;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst/busy", 64'(div_busy), 64'd0);
        check("arst/valid", 64'(div_wb_valid), 64'd0);
        check("arst/wren", 64'(div_wb_rd_wr_en), 64'd0);
        check("arst/rd", 64'(div_wb_rd_addr), 64'd0);
        check("arst/data", 64'(div_wb_data), 64'd0);
        check("arst/tag", 64'(div_wb_instr_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (div_wb_valid) wb_cnt++;
        end
        check("arst/nowb", 64'(wb_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
